// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave SDA datapath.
// Combinational only: no latency.
// No flow control: these are only types and constants.
package i2c_slave_pkg;

  // Data-phase sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    TX_BIT,
    TX_ACK,
    RX_BIT,
    RX_ACK
  } seq_state_t;

  // Open-drain pad: a 1 on the output lets the pull-up own the line.
  localparam logic SDA_RELEASE       = 1'b1;
  localparam logic ACK_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/slave_sda_sequencer_if.sv
// Bundles the SCL strobes, transmit byte handshake and SDA drive of the slave data phase.
// Wires only: no latency.
// tx_valid/tx_ready: a byte is taken only at frame load; tx_ready pulses for one cycle when it is.
interface slave_sda_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic                  start;
  logic                  rw;
  logic                  stop;
  logic                  scl_fall;
  logic                  scl_rise;
  logic                  sda_in;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  ack_enable;
  logic                  slave_mux_sel;
  logic                  slave_mux_out;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  byte_done;
  logic                  master_nack;
  logic                  underrun;

  // Slave protocol engine side: drives bus events and the transmit byte.
  modport master (
    output start, rw, stop, scl_fall, scl_rise, sda_in, tx_data, tx_valid, ack_enable,
    input  tx_ready, slave_mux_sel, slave_mux_out, bit_cnt, byte_done, master_nack, underrun
  );

  // Sequencer side: consumes events, drives SDA select/level and status.
  modport slave (
    input  start, rw, stop, scl_fall, scl_rise, sda_in, tx_data, tx_valid, ack_enable,
    output tx_ready, slave_mux_sel, slave_mux_out, bit_cnt, byte_done, master_nack, underrun
  );
endinterface

// File: rtl/slave_tx_shifter.sv
// Parallel-load / shift-left register holding the transmit bits still to be driven.
// Load or shift takes effect on the next clk; msb is the bit that the next shift exposes.
// No backpressure: load and shift are obeyed every cycle, load wins.
module slave_tx_shifter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift,
  output logic                  msb
);

  logic [DATA_WIDTH-1:0] sr;

  // Shift in ones so that running past the end of a frame reads as released SDA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '1;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      sr <= {sr[DATA_WIDTH-2:0], 1'b1};
    end
  end

  assign msb = sr[DATA_WIDTH-1];

endmodule

// File: rtl/slave_sda_sequencer.sv
// Drives SDA select/level for the slave data phase: serialises TX bytes, samples master ACK, drives slave ACK.
// SDA changes one clk after the scl_fall strobe; all outputs are registered.
// tx_ready pulses when a byte is loaded; with tx_valid low the frame goes out as all-ones and underrun sticks.
module slave_sda_sequencer
  import i2c_slave_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic ACK_LEVEL  = ACK_LEVEL_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  slave_sda_sequencer_if.slave bus
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  seq_state_t            state_q, state_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic                  sel_q, sel_nxt;
  logic                  out_q, out_nxt;
  logic                  tx_ready_q, tx_ready_nxt;
  logic                  byte_done_q, byte_done_nxt;
  logic                  nack_q, nack_nxt;
  logic                  underrun_q, underrun_nxt;

  logic                  do_load;
  logic                  sh_load;
  logic                  sh_shift;
  logic                  sh_msb;
  logic [DATA_WIDTH-1:0] load_val;

  // The first bit of a frame goes straight into the SDA register at load time,
  // so the shifter only holds the bits that follow it.
  slave_tx_shifter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_data ({load_val[DATA_WIDTH-2:0], 1'b1}),
    .shift     (sh_shift),
    .msb       (sh_msb)
  );

  // Next state, next SDA drive and status pulses; stop beats start beats SCL strobes.
  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    sel_nxt       = sel_q;
    out_nxt       = out_q;
    tx_ready_nxt  = 1'b0;
    byte_done_nxt = 1'b0;
    nack_nxt      = nack_q;
    underrun_nxt  = underrun_q;
    do_load       = 1'b0;
    sh_load       = 1'b0;
    sh_shift      = 1'b0;
    load_val      = bus.tx_valid ? bus.tx_data : '1;

    if (bus.stop) begin
      state_nxt = IDLE;
      sel_nxt   = 1'b0;
      out_nxt   = SDA_RELEASE;
      cnt_nxt   = '0;
    end else if (bus.start) begin
      // Also covers a repeated start: whatever frame was running is dropped.
      nack_nxt     = 1'b0;
      underrun_nxt = 1'b0;
      cnt_nxt      = '0;
      if (bus.rw) begin
        do_load = 1'b1;
      end else begin
        state_nxt = RX_BIT;
        sel_nxt   = 1'b0;
        out_nxt   = SDA_RELEASE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          sel_nxt = 1'b0;
          out_nxt = SDA_RELEASE;
        end
        TX_BIT: begin
          if (bus.scl_fall) begin
            if (cnt_q == LAST_BIT) begin
              state_nxt = TX_ACK;
              sel_nxt   = 1'b0;
              out_nxt   = SDA_RELEASE;
              cnt_nxt   = '0;
            end else begin
              sh_shift = 1'b1;
              out_nxt  = sh_msb;
              cnt_nxt  = cnt_q + CNT_W'(1);
            end
          end
        end
        TX_ACK: begin
          // A coincident rise is ignored: the fall closes the slot.
          if (bus.scl_fall) begin
            if (nack_q) begin
              state_nxt = IDLE;
              sel_nxt   = 1'b0;
              out_nxt   = SDA_RELEASE;
            end else begin
              do_load = 1'b1;
            end
          end else if (bus.scl_rise) begin
            nack_nxt = (bus.sda_in != ACK_LEVEL);
          end
        end
        RX_BIT: begin
          sel_nxt = 1'b0;
          if (bus.scl_fall) begin
            if (cnt_q == LAST_BIT) begin
              state_nxt     = RX_ACK;
              byte_done_nxt = 1'b1;
              out_nxt       = bus.ack_enable ? ACK_LEVEL : ~ACK_LEVEL;
              cnt_nxt       = '0;
            end else begin
              out_nxt = SDA_RELEASE;
              cnt_nxt = cnt_q + CNT_W'(1);
            end
          end
        end
        RX_ACK: begin
          if (bus.scl_fall) begin
            state_nxt = RX_BIT;
            out_nxt   = SDA_RELEASE;
          end
        end
        default: begin
          state_nxt = IDLE;
          sel_nxt   = 1'b0;
          out_nxt   = SDA_RELEASE;
          cnt_nxt   = '0;
        end
      endcase
    end

    // Frame load shared by start-to-transmit and the ACKed end of a transmit frame.
    if (do_load) begin
      state_nxt = TX_BIT;
      sh_load   = 1'b1;
      sel_nxt   = 1'b1;
      out_nxt   = load_val[DATA_WIDTH-1];
      if (bus.tx_valid) begin
        tx_ready_nxt = 1'b1;
      end else begin
        underrun_nxt = 1'b1;
      end
    end
  end

  // State and output registers; reset leaves SDA released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      out_q       <= SDA_RELEASE;
      tx_ready_q  <= 1'b0;
      byte_done_q <= 1'b0;
      nack_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      sel_q       <= sel_nxt;
      out_q       <= out_nxt;
      tx_ready_q  <= tx_ready_nxt;
      byte_done_q <= byte_done_nxt;
      nack_q      <= nack_nxt;
      underrun_q  <= underrun_nxt;
    end
  end

  assign bus.slave_mux_sel = sel_q;
  assign bus.slave_mux_out = out_q;
  assign bus.bit_cnt       = cnt_q;
  assign bus.tx_ready      = tx_ready_q;
  assign bus.byte_done     = byte_done_q;
  assign bus.master_nack   = nack_q;
  assign bus.underrun      = underrun_q;

endmodule

// File: tb/tb_slave_sda_sequencer.sv
// Bench for slave_sda_sequencer at DATA_WIDTH 8 and 16 driven by a shared SCL/bus model.
// Expected SDA slots are queued when a frame is started and popped at each SCL high.
// Inputs change 1ns after posedge; outputs are sampled at that same point.
module tb_slave_sda_sequencer;

  logic        clk;
  logic        rst;
  logic        start, rw, stop, scl_fall, scl_rise, sda_in, tx_valid, ack_enable;
  logic [7:0]  tx_data8;
  logic [15:0] tx_data16;
  logic        use16;

  int checks;
  int failures;
  int tx_rdy8;
  int tx_rdy16;
  int bdone8;
  int snap;

  // {bit_cnt[3:0], sel, out}
  logic [5:0] sb_q[$];

  slave_sda_sequencer_if #(.DATA_WIDTH(8))  bus8();
  slave_sda_sequencer_if #(.DATA_WIDTH(16)) bus16();

  assign bus8.start       = start;
  assign bus8.rw          = rw;
  assign bus8.stop        = stop;
  assign bus8.scl_fall    = scl_fall;
  assign bus8.scl_rise    = scl_rise;
  assign bus8.sda_in      = sda_in;
  assign bus8.tx_data     = tx_data8;
  assign bus8.tx_valid    = tx_valid;
  assign bus8.ack_enable  = ack_enable;
  assign bus16.start      = start;
  assign bus16.rw         = rw;
  assign bus16.stop       = stop;
  assign bus16.scl_fall   = scl_fall;
  assign bus16.scl_rise   = scl_rise;
  assign bus16.sda_in     = sda_in;
  assign bus16.tx_data    = tx_data16;
  assign bus16.tx_valid   = tx_valid;
  assign bus16.ack_enable = ack_enable;

  slave_sda_sequencer #(.DATA_WIDTH(8), .ACK_LEVEL(1'b0)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  slave_sda_sequencer #(.DATA_WIDTH(16), .ACK_LEVEL(1'b0)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (bus8.tx_ready)  tx_rdy8++;
    if (bus16.tx_ready) tx_rdy16++;
    if (bus8.byte_done) bdone8++;
  end

  // Coincident SCL edges are illegal stimulus.
  always @(posedge clk) begin
    if (!rst) assert (!(scl_fall && scl_rise)) else $error("scl_fall and scl_rise in the same cycle");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_slot(input int cnt, input logic sel, input logic out);
    sb_q.push_back({cnt[3:0], sel, out});
  endtask

  task automatic push_tx8(input logic [7:0] b);
    for (int i = 0; i < 8; i++) push_slot(i, 1'b1, b[7-i]);
  endtask

  task automatic check_slot();
    logic [5:0] act;
    if (use16) act = {bus16.bit_cnt, bus16.slave_mux_sel, bus16.slave_mux_out};
    else       act = {1'b0, bus8.bit_cnt, bus8.slave_mux_sel, bus8.slave_mux_out};
    if (sb_q.size() == 0) check_val("sb_empty", 32'(sb_q.size()), 32'd1);
    else                  check_val("slot", 32'(act), 32'(sb_q.pop_front()));
  endtask

  // One SCL period: low phase, rise (master level on SDA), check while high, fall.
  task automatic scl_bit(input logic m_sda);
    cyc(2);
    sda_in   = m_sda;
    scl_rise = 1'b1;
    cyc(1);
    scl_rise = 1'b0;
    check_slot();
    scl_fall = 1'b1;
    cyc(1);
    scl_fall = 1'b0;
  endtask

  task automatic pulse_start(input logic dir);
    rw    = dir;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(1);
  endtask

  task automatic check_outs8(input string tag, input logic sel, input logic out, input logic [2:0] cnt);
    check_val({tag, "_sel"}, 32'(bus8.slave_mux_sel), 32'(sel));
    check_val({tag, "_out"}, 32'(bus8.slave_mux_out), 32'(out));
    check_val({tag, "_cnt"}, 32'(bus8.bit_cnt), 32'(cnt));
  endtask

  initial begin
    checks = 0; failures = 0; tx_rdy8 = 0; tx_rdy16 = 0; bdone8 = 0;
    rst = 1'b1; start = 1'b0; rw = 1'b0; stop = 1'b0; scl_fall = 1'b0; scl_rise = 1'b0;
    sda_in = 1'b1; tx_valid = 1'b0; ack_enable = 1'b1; tx_data8 = 8'h00; tx_data16 = 16'h0000;
    use16 = 1'b0;

    // Reset values.
    cyc(2);
    check_outs8("rst", 1'b0, 1'b1, 3'd0);
    check_val("rst_txrdy", 32'(bus8.tx_ready), 32'd0);
    check_val("rst_bdone", 32'(bus8.byte_done), 32'd0);
    check_val("rst_nack", 32'(bus8.master_nack), 32'd0);
    check_val("rst_undr", 32'(bus8.underrun), 32'd0);
    rst = 1'b0;
    cyc(2);

    // Transmit 0xA5 (ACKed) then 0x3C (NACKed).
    snap = tx_rdy8;
    tx_valid = 1'b1;
    tx_data8 = 8'hA5;
    push_tx8(8'hA5); push_slot(0, 1'b0, 1'b1);
    push_tx8(8'h3C); push_slot(0, 1'b0, 1'b1);
    pulse_start(1'b1);
    tx_data8 = 8'h3C;
    for (int i = 0; i < 8; i++) scl_bit(1'b1);
    scl_bit(1'b0);
    for (int i = 0; i < 8; i++) scl_bit(1'b1);
    scl_bit(1'b1);
    cyc(1);
    check_outs8("tx_end", 1'b0, 1'b1, 3'd0);
    check_val("tx_nack", 32'(bus8.master_nack), 32'd1);
    check_val("tx_rdy_cnt", 32'(tx_rdy8 - snap), 32'd2);
    tx_valid = 1'b0;

    // Receive two bytes: ACK then NACK.
    snap = bdone8;
    pulse_start(1'b0);
    for (int i = 0; i < 8; i++) push_slot(i, 1'b0, 1'b1);
    push_slot(0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) push_slot(i, 1'b0, 1'b1);
    push_slot(0, 1'b0, 1'b1);
    ack_enable = 1'b1;
    for (int i = 0; i < 8; i++) scl_bit(1'b1);
    check_val("rx_bdone1", 32'(bus8.byte_done), 32'd1);
    scl_bit(1'b0);
    ack_enable = 1'b0;
    for (int i = 0; i < 8; i++) scl_bit(1'b1);
    check_val("rx_bdone2", 32'(bus8.byte_done), 32'd1);
    scl_bit(1'b1);
    check_val("rx_bdone_cnt", 32'(bdone8 - snap), 32'd2);
    pulse_stop();

    // Underrun: transmit start with no valid byte.
    snap = tx_rdy8;
    tx_valid = 1'b0;
    tx_data8 = 8'h00;
    pulse_start(1'b1);
    check_val("ur_flag", 32'(bus8.underrun), 32'd1);
    for (int i = 0; i < 8; i++) push_slot(i, 1'b1, 1'b1);
    push_slot(0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) scl_bit(1'b1);
    check_val("ur_rdy_cnt", 32'(tx_rdy8 - snap), 32'd0);
    check_val("ur_sticky", 32'(bus8.underrun), 32'd1);

    // Stop coinciding with scl_fall at bit 4.
    tx_valid = 1'b1;
    tx_data8 = 8'hF0;
    pulse_start(1'b1);
    tx_valid = 1'b0;
    for (int i = 0; i < 5; i++) push_slot(i, 1'b1, tx_data8[7-i]);
    for (int i = 0; i < 4; i++) scl_bit(1'b1);
    cyc(2);
    scl_rise = 1'b1;
    cyc(1);
    scl_rise = 1'b0;
    check_slot();
    scl_fall = 1'b1;
    stop = 1'b1;
    cyc(1);
    scl_fall = 1'b0;
    stop = 1'b0;
    check_outs8("stop", 1'b0, 1'b1, 3'd0);
    cyc(2);

    // Repeated start mid-receive switches straight to transmit.
    pulse_start(1'b0);
    for (int i = 0; i < 3; i++) push_slot(i, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) scl_bit(1'b1);
    tx_valid = 1'b1;
    tx_data8 = 8'h5A;
    pulse_start(1'b1);
    tx_valid = 1'b0;
    check_outs8("rs", 1'b1, 1'b0, 3'd0);
    check_val("rs_txrdy", 32'(bus8.tx_ready), 32'd1);
    pulse_stop();

    // Asynchronous reset in the ACK slot of an underrun frame NACKed by the master.
    pulse_start(1'b1);
    for (int i = 0; i < 8; i++) push_slot(i, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) scl_bit(1'b1);
    cyc(2);
    sda_in = 1'b1;
    scl_rise = 1'b1;
    cyc(1);
    scl_rise = 1'b0;
    check_val("ar_pre_nack", 32'(bus8.master_nack), 32'd1);
    check_val("ar_pre_undr", 32'(bus8.underrun), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_outs8("ar", 1'b0, 1'b1, 3'd0);
    check_val("ar_nack", 32'(bus8.master_nack), 32'd0);
    check_val("ar_undr", 32'(bus8.underrun), 32'd0);
    check_val("ar_txrdy", 32'(bus8.tx_ready), 32'd0);
    check_val("ar_bdone", 32'(bus8.byte_done), 32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(2);

    // 16-bit frame: ACK slot at bit_cnt rollover, then reload of the next word.
    use16 = 1'b1;
    snap = tx_rdy16;
    tx_valid = 1'b1;
    tx_data16 = 16'hC3A5;
    for (int i = 0; i < 16; i++) push_slot(i, 1'b1, tx_data16[15-i]);
    push_slot(0, 1'b0, 1'b1);
    pulse_start(1'b1);
    tx_data16 = 16'h7FFE;
    for (int i = 0; i < 16; i++) scl_bit(1'b1);
    scl_bit(1'b0);
    check_val("w16_sel", 32'(bus16.slave_mux_sel), 32'd1);
    check_val("w16_out", 32'(bus16.slave_mux_out), 32'd0);
    check_val("w16_cnt", 32'(bus16.bit_cnt), 32'd0);
    check_val("w16_nack", 32'(bus16.master_nack), 32'd0);
    cyc(1);
    check_val("w16_rdy_cnt", 32'(tx_rdy16 - snap), 32'd2);
    tx_valid = 1'b0;
    pulse_stop();
    use16 = 1'b0;

    check_val("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slave_sda_sequencer.md
Name: slave_sda_sequencer

Overview:
Parametrised SDA output sequencer for the I2C slave. It generates both the mux select and the SDA output level for the whole data phase, so the slave no longer steers these by hand. Per frame it serialises DATA_WIDTH-bit transmit bytes MSB-first and samples the master's ACK/NACK, or releases SDA during receive bytes and drives the slave ACK/NACK. It sits after the SCL edge detector and start/stop detector, and drives the open-drain SDA pad logic.

Parameters:
DATA_WIDTH, 8, bits per data frame before the ACK slot
ACK_LEVEL, 0, SDA level meaning ACK (NACK = ~ACK_LEVEL)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse in SCL-low after address ACK; begins data phase
rw  input  1  sampled on start; 1 = slave transmits, 0 = slave receives
stop  input  1  one-cycle pulse, STOP detected on bus
scl_fall  input  1  one-cycle strobe, SCL falling edge
scl_rise  input  1  one-cycle strobe, SCL rising edge
sda_in  input  1  synchronised SDA bus level
tx_data  input  DATA_WIDTH  next byte to transmit
tx_valid  input  1  tx_data holds a valid byte
tx_ready  output  1  one-cycle pulse, tx_data consumed
ack_enable  input  1  1 = ACK the received byte, 0 = NACK it
slave_mux_sel  output  1  1 = data bit on SDA, 0 = ACK slot / released
slave_mux_out  output  1  SDA level to pad; 1 = released
bit_cnt  output  $clog2(DATA_WIDTH)  index of the current bit in the frame
byte_done  output  1  one-cycle pulse, receive frame complete
master_nack  output  1  registered NACK from master, last transmit frame
underrun  output  1  sticky until next start; frame loaded while tx_valid=0

Behaviour:
- Reset: state IDLE, slave_mux_out=1, slave_mux_sel=0, bit_cnt=0, tx_ready=0, byte_done=0, master_nack=0, underrun=0, shift register all-ones. All outputs are registered.
- States: IDLE, TX_BIT, TX_ACK, RX_BIT, RX_ACK.
- IDLE: SDA released. On start, latch rw, clear master_nack and underrun, bit_cnt=0.
  - rw=1: load tx_data (all-ones and set underrun if tx_valid=0), pulse tx_ready if valid. Next cycle: sel=1, out=MSB. Go to TX_BIT.
  - rw=0: go to RX_BIT.
- TX_BIT: each scl_fall shifts left and increments bit_cnt. On scl_fall with bit_cnt=DATA_WIDTH-1: sel=0, out=1, bit_cnt=0, go to TX_ACK.
- TX_ACK: on scl_rise, master_nack <= (sda_in != ACK_LEVEL). On scl_fall:
  - master_nack=1: go to IDLE, SDA released.
  - otherwise: load the next byte (same tx_valid/underrun rule), sel=1, out=MSB, go to TX_BIT.
- RX_BIT: sel=0, out=1. Each scl_fall increments bit_cnt. On scl_fall with bit_cnt=DATA_WIDTH-1: pulse byte_done, out = ack_enable ? ACK_LEVEL : ~ACK_LEVEL, bit_cnt=0, go to RX_ACK. ack_enable is sampled on that same cycle.
- RX_ACK: on scl_fall, out=1 and go to RX_BIT.
- Latency: SDA changes exactly one clk after the scl_fall strobe, which is well inside SCL low.
- stop in any state: IDLE next cycle, SDA released, bit_cnt=0. stop takes priority over scl_fall/start in the same cycle.
- start in a non-IDLE state (repeated start): abort the current frame and restart as from IDLE.
- scl_fall and scl_rise in the same cycle is illegal. scl_fall wins and rise is ignored; the bench flags it with an assertion.
- rst mid-frame returns every output to its reset value immediately, with SDA released.
- bit_cnt wraps only through the explicit reset to 0 on frame end. No modulo arithmetic.

Decomposition:
- Package i2c_slave_pkg: state enum (IDLE, TX_BIT, TX_ACK, RX_BIT, RX_ACK), constants SDA_RELEASE=1'b1 and default ACK_LEVEL.
- One sub-module, slave_tx_shifter: DATA_WIDTH parallel-load/shift-left register with load, shift and msb ports, filled with ones on reset.
- The legacy slave_mux function is absorbed into this block's output register.

Test Plan:
- Transmit 0xA5 then master ACK, 0x3C then master NACK. Expect SDA sequence 1,0,1,0,0,1,0,1, release, 0,0,1,1,1,1,0,0, release, then IDLE; master_nack=1; two tx_ready pulses.
- Receive 8 bits with ack_enable=1 then ack_enable=0. Expect byte_done pulse on the 8th scl_fall, SDA=0 in the first ACK slot and 1 in the second, released otherwise.
- start with rw=1, tx_valid=0. Expect underrun=1, SDA stays 1 for all 8 bits, no tx_ready pulse.
- stop asserted at bit 4 of a TX frame, same cycle as scl_fall. Expect IDLE next cycle, slave_mux_out=1, bit_cnt=0.
- Repeated start mid-RX frame with rw=1. Expect immediate reload of tx_data, sel=1, MSB driven, bit_cnt=0.
- rst asserted asynchronously during TX_ACK. Expect all outputs at reset values before the next clk edge. DATA_WIDTH=16 regression: 16-bit frame with ACK slot at bit_cnt rollover.
